ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 9 +
 rtl/ifetch_fifo.sv | 45 ++++
 rtl/ifetch_unit.sv | 98 +++++++++
 tb/tb_ifetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and the fetch buffer entry type for the instruction fetch unit.
package ifetch_pkg;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch entries.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, flush (empties the buffer; a push or pop
// in the flush cycle is discarded), full, empty, count (occupancy).
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    always_comb begin
        full    = count == (AW+1)'(DEPTH);
        empty   = count == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rp];
    end
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: in-order instruction fetch with redirect, stale-response dropping and a decode buffer.
// Ports: clk, rst (sync, active-high); redirect_valid/redirect_pc from execute;
// imem_req_valid/ready/addr request channel; imem_resp_valid/data response channel (in order);
// dec_valid/ready/instr/pc towards decode; dec_misalign only when IFETCH_MISALIGN_TRAP_EN is defined.
// Macro IFETCH_MISALIGN_TRAP_EN: a misaligned redirect traps to decode and stalls fetch;
// without it the low two bits of redirect_pc are ignored.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [DATA_WIDTH-1:0] dec_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic                  dec_misalign
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(INSTR_BYTES);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;
    logic [DATA_WIDTH-1:0] fetch_pc, resp_pc, tgt;
    logic [CW-1:0] out_cnt, drop_cnt, occ, out_next;
    logic accept, resp, drop, push, pop, stall, fifo_full, fifo_empty;
    entry_t fifo_in, fifo_out;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic mis_q;
    assign stall        = mis_q;
    assign tgt          = redirect_pc;
    assign dec_misalign = !rst && mis_q;
`else
    assign stall = 1'b0;
    assign tgt   = redirect_pc & ~DATA_WIDTH'(3);
`endif
    // Requests in flight plus buffered entries never exceed the buffer, so every response has a slot.
    always_comb begin
        imem_req_valid = !rst && !stall && (int'(out_cnt) + int'(occ) < FIFO_DEPTH);
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        resp           = imem_resp_valid && out_cnt != '0;
        drop           = resp && drop_cnt != '0;
        push           = resp && !drop && !redirect_valid && !fifo_full;
        out_next       = out_cnt + CW'(accept) - CW'(resp);
        dec_valid      = !rst && (!fifo_empty || stall);
        pop            = dec_valid && dec_ready && !redirect_valid;
        dec_pc         = stall ? resp_pc : fifo_out.pc;
        dec_instr      = stall ? '0 : fifo_out.instr;
        fifo_in        = '{pc: resp_pc, instr: imem_resp_data};
    end
    // On redirect everything still outstanding (including this cycle's accept) becomes stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            out_cnt  <= out_next;
            fetch_pc <= redirect_valid ? tgt : accept ? fetch_pc + STEP : fetch_pc;
            resp_pc  <= redirect_valid ? tgt : push ? resp_pc + STEP : resp_pc;
            drop_cnt <= redirect_valid ? out_next : drop ? drop_cnt - 1'b1 : drop_cnt;
`ifdef IFETCH_MISALIGN_TRAP_EN
            mis_q    <= redirect_valid ? redirect_pc[1:0] != 2'b00 : mis_q;
`endif
        end
    end
    ifetch_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_in),
        .dout  (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit with a fixed-latency instruction memory model.
module tb_ifetch_unit;
    localparam logic [31:0] K = 32'h5A5A_0000;
    logic clk = 1'b0;
    logic rst, redirect_valid, imem_req_valid, imem_req_ready, dec_valid, dec_ready;
    logic imem_resp_valid = 1'b0;
    logic [31:0] redirect_pc, imem_req_addr, dec_instr, dec_pc;
    logic [31:0] imem_resp_data = '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic dec_misalign;
`endif
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    logic [31:0] sb[$];
    logic [31:0] exp_addr = '0;
    logic [31:0] mon_e;
    int total = 0, bad = 0, cyc = 0, lat = 1, acc_cnt = 0;

    ifetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .dec_misalign    (dec_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: answers each accepted request after lat cycles with addr^K; also tracks the
    // expected fetch address and feeds expected decode entries into the scoreboard.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            mq.delete();
            sb.delete();
            exp_addr = '0;
            acc_cnt = 0;
            imem_resp_valid = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            if (mq.size() != 0 && mq[0].due == cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data = mq[0].addr ^ K;
                void'(mq.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_addr);
                mq.push_back('{imem_req_addr, cyc + lat});
                acc_cnt++;
                if (!redirect_valid) sb.push_back(exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
            if (redirect_valid) begin
                sb.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
                exp_addr = redirect_pc;
`else
                exp_addr = redirect_pc & ~32'h3;
`endif
            end
        end
    end

    // Monitor: every decode handshake must match the oldest expected entry.
    always @(negedge clk) begin
        #1;
        if (!rst && dec_valid && dec_ready && !redirect_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
            && !dec_misalign
`endif
        ) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc %h want no entry", dec_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_pc", dec_pc, mon_e);
                chk("sb_instr", dec_instr, mon_e ^ K);
            end
        end
    end

    task automatic expect_dec(string name, logic [31:0] pc);
        bit found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            #2;
            if (dec_valid && !redirect_valid) begin
                chk(name, dec_pc, pc);
                found = 1'b1;
            end
            @(negedge clk);
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: no dec_valid within 30 cycles, want pc %h", name, pc);
        end
    endtask

    task automatic do_reset(int lat_v, logic dr);
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        dec_ready = dr;
        lat = lat_v;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        dec_ready = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        chk("drain_sb_empty", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic redirect(logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int acc0;
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        dec_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_dec_valid", dec_valid, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("rst_misalign", dec_misalign, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t1_req_valid", imem_req_valid, 1);
            chk("t1_addr", imem_req_addr, 32'(i * 4));
            if (i == 1) chk("t1_dec_latency", dec_valid, 0);
            if (i == 2) begin
                chk("t1_dec_valid", dec_valid, 1);
                chk("t1_dec_pc", dec_pc, 0);
            end
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        drain();

        do_reset(1, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        chk("t2_req_count", acc_cnt, 4);
        chk("t2_req_valid", imem_req_valid, 0);
        chk("t2_dec_valid", dec_valid, 1);
        chk("t2_head_pc", dec_pc, 0);
        @(negedge clk);
        dec_ready = 1'b1;
        repeat (8) @(negedge clk);
        drain();

        do_reset(3, 1'b1);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #2;
        chk("t3_stale_req_addr", imem_req_addr, 32'h8);
        @(negedge clk);
        redirect_valid = 1'b0;
        expect_dec("t3_first_pc", 32'h100);
        repeat (6) @(negedge clk);
        drain();

        do_reset(3, 1'b1);
        repeat (6) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #2;
        chk("t4_resp_same_cycle", imem_resp_valid, 1);
        chk("t4_req_same_cycle", imem_req_valid, 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        expect_dec("t4_first_pc", 32'h200);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h340;
        @(negedge clk);
        redirect_valid = 1'b0;
        expect_dec("t4_b2b_pc", 32'h340);
        repeat (4) @(negedge clk);
        drain();

        do_reset(1, 1'b1);
        repeat (3) @(negedge clk);
        redirect(32'hFFFF_FFF8);
        expect_dec("t5_wrap0", 32'hFFFF_FFF8);
        expect_dec("t5_wrap1", 32'hFFFF_FFFC);
        expect_dec("t5_wrap2", 32'h0000_0000);
        drain();

        do_reset(1, 1'b1);
        repeat (3) @(negedge clk);
        redirect(32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
        #2;
        chk("t6_misalign", dec_misalign, 1);
        chk("t6_dec_valid", dec_valid, 1);
        chk("t6_dec_pc", dec_pc, 32'h102);
        chk("t6_dec_instr", dec_instr, 0);
        acc0 = acc_cnt;
        repeat (5) @(negedge clk);
        #2;
        chk("t6_stall_valid", imem_req_valid, 0);
        chk("t6_stall_count", acc_cnt, acc0);
        @(negedge clk);
        redirect(32'h400);
        expect_dec("t6_resume_pc", 32'h400);
        #2;
        chk("t6_misalign_clear", dec_misalign, 0);
        @(negedge clk);
`else
        acc0 = 0;
        expect_dec("t6_aligned_pc", 32'h100 + 32'(acc0));
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
